// File: rtl/mprj_cfg_pkg.sv
// Shared definitions for the mprj_io pad configuration loader.
//   - state_t      : loader FSM states (also exported on the debug port)
//   - CFG_*        : bit positions inside one 13-bit pad config word
//   - CFG_MODE_*   : commonly used complete pad config words
//   - cfg_pack()   : builds a config word from its most-used fields
package mprj_cfg_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_SETUP = 3'd2,
    S_HIGH  = 3'd3,
    S_LOAD  = 3'd4,
    S_FIN   = 3'd5
  } state_t;

  localparam int CFG_W = 13;

  // Field positions inside a pad config word (bit 12 is shifted first).
  localparam int CFG_MGMT_EN      = 0;
  localparam int CFG_OEB          = 1;
  localparam int CFG_HOLDOVER     = 2;
  localparam int CFG_INP_DIS      = 3;
  localparam int CFG_IB_MODE_SEL  = 4;
  localparam int CFG_ANALOG_EN    = 5;
  localparam int CFG_ANALOG_SEL   = 6;
  localparam int CFG_ANALOG_POL   = 7;
  localparam int CFG_SLOW_SEL     = 8;
  localparam int CFG_VTRIP_SEL    = 9;
  localparam int CFG_DM_LSB       = 10;
  localparam int CFG_DM_MSB       = 12;

  // Power-on pad mode: management-owned, dm=3'b110, output disabled.
  localparam logic [CFG_W-1:0] CFG_MODE_MGMT_BIDIR   = 13'h1803;
  localparam logic [CFG_W-1:0] CFG_MODE_USER_STD_OUT = 13'h1808;
  localparam logic [CFG_W-1:0] CFG_MODE_USER_IN_NOPL = 13'h0402;

  function automatic logic [CFG_W-1:0] cfg_pack(input logic [2:0] dm,
                                                input logic       oeb,
                                                input logic       mgmt_en);
    logic [CFG_W-1:0] w;
    w = '0;
    w[CFG_DM_MSB:CFG_DM_LSB] = dm;
    w[CFG_OEB]               = oeb;
    w[CFG_MGMT_EN]           = mgmt_en;
    return w;
  endfunction

endpackage

// File: rtl/mprj_io_cfg_loader_if.sv
// Management-core side of the pad config loader.
//   start/abort        : requests from the management core
//   busy/done/aborted  : loader status
//   cfg_idx/cfg_word   : register-file read port (index out, word back)
//
// Handshake: start is a 1-cycle request honoured only while busy=0; busy
// stays high from the cycle after start until the load ends; exactly one
// of done/aborted pulses for one cycle to end it. abort is honoured only
// while busy=1 (and not in the final done cycle). cfg_word must reflect
// cfg_idx combinationally within the cycle after cfg_idx changes.
interface mprj_io_cfg_loader_if #(
  parameter int NUM_PADS = 38,
  parameter int CFG_BITS = 13
) ();
  localparam int IDX_W = $clog2(NUM_PADS);

  logic                start;
  logic                abort;
  logic                busy;
  logic                done;
  logic                aborted;
  logic [IDX_W-1:0]    cfg_idx;
  logic [CFG_BITS-1:0] cfg_word;

  modport master (
    output start, abort, cfg_word,
    input  busy, done, aborted, cfg_idx
  );

  modport slave (
    input  start, abort, cfg_word,
    output busy, done, aborted, cfg_idx
  );
endinterface

// File: rtl/mprj_cfg_shifter.sv
// Datapath for one pad word: shift register, remaining-bit counter and
// the half-period timer shared by the SETUP/HIGH/LOAD phases.
//   load_i     : capture word_i, arm bit counter to CFG_BITS-1
//   step_i     : shift left one bit, count down (stops at 0)
//   hc_clr_i   : restart the half-period timer (otherwise it counts up)
//   next_msb_o : MSB the shift register will present after this edge
//   last_bit_o : the bit currently on the wire is the word's last one
//   hc_done_o  : current phase has lasted HALF cycles
module mprj_cfg_shifter #(
  parameter int CFG_BITS = 13,
  parameter int HALF     = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                load_i,
  input  logic                step_i,
  input  logic                hc_clr_i,
  input  logic [CFG_BITS-1:0] word_i,
  output logic                next_msb_o,
  output logic                last_bit_o,
  output logic                hc_done_o
);
  localparam int CNT_W = $clog2(CFG_BITS);
  localparam int HC_W  = $clog2(HALF + 1);

  logic [CFG_BITS-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [HC_W-1:0]     hcnt_q, hcnt_d;

  always_comb begin
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    if (load_i) begin
      shreg_d   = word_i;
      bit_cnt_d = CNT_W'(CFG_BITS - 1);
    end else if (step_i) begin
      shreg_d = shreg_q << 1;
      if (bit_cnt_q != '0) bit_cnt_d = bit_cnt_q - CNT_W'(1);
    end
    hcnt_d = hc_clr_i ? '0 : hcnt_q + HC_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      hcnt_q    <= '0;
    end else begin
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      hcnt_q    <= hcnt_d;
    end
  end

  // The FSM registers serial_data on the same edge that loads/shifts, so
  // it needs the post-edge MSB ahead of time.
  assign next_msb_o = load_i ? word_i[CFG_BITS-1] : shreg_q[CFG_BITS-2];
  assign last_bit_o = (bit_cnt_q == '0);
  assign hc_done_o  = (hcnt_q == HC_W'(HALF - 1));
endmodule

// File: rtl/mprj_io_cfg_loader.sv
// Serial loader for the mprj_io pad configuration chain. On start it walks
// pads NUM_PADS-1 down to 0, fetching each config word and shifting it
// MSB-first with a serial clock of 2*HALF wb_clk_i cycles, then strobes
// serial_load for HALF cycles so every pad adopts its new config at once.
//   wb_clk_i, wb_rst_i : clock, synchronous active-high reset
//   host               : start/abort/busy/done/aborted + cfg_idx/cfg_word
//   serial_clock/data  : chain shift clock and data (data stable while high)
//   serial_load        : chain latch strobe
//   serial_resetn      : chain reset, low only while wb_rst_i is applied
//   dbg_state_o        : current FSM state
module mprj_io_cfg_loader
  import mprj_cfg_pkg::*;
#(
  parameter int NUM_PADS = 38,
  parameter int CFG_BITS = 13,
  parameter int HALF     = 2
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  mprj_io_cfg_loader_if.slave host,
  output logic                serial_clock,
  output logic                serial_data,
  output logic                serial_load,
  output logic                serial_resetn,
  output state_t              dbg_state_o
);
  localparam int               IDX_W    = $clog2(NUM_PADS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PADS - 1);

  state_t           state_q;
  logic             busy_q, done_q, aborted_q;
  logic             sclk_q, sdata_q, sload_q, sresetn_q;
  logic [IDX_W-1:0] cfg_idx_q;

  logic in_timed, abort_hit, sh_load, sh_step, hc_clr;
  logic next_msb, last_bit, hc_done;

  assign in_timed  = (state_q == S_SETUP) || (state_q == S_HIGH) || (state_q == S_LOAD);
  // FIN is deliberately excluded: once the latch pulse is out, finish cleanly.
  assign abort_hit = host.abort && (in_timed || (state_q == S_FETCH));
  assign sh_load   = (state_q == S_FETCH) && !host.abort;
  assign sh_step   = (state_q == S_HIGH) && hc_done && !host.abort;
  // Timer idles at 0 outside timed phases and restarts at each phase end,
  // so every SETUP/HIGH/LOAD entry begins from zero.
  assign hc_clr    = !in_timed || hc_done || host.abort;

  mprj_cfg_shifter #(
    .CFG_BITS (CFG_BITS),
    .HALF     (HALF)
  ) u_shifter (
    .clk_i      (wb_clk_i),
    .rst_i      (wb_rst_i),
    .load_i     (sh_load),
    .step_i     (sh_step),
    .hc_clr_i   (hc_clr),
    .word_i     (host.cfg_word),
    .next_msb_o (next_msb),
    .last_bit_o (last_bit),
    .hc_done_o  (hc_done)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      sclk_q    <= 1'b0;
      sdata_q   <= 1'b0;
      sload_q   <= 1'b0;
      sresetn_q <= 1'b0;
      cfg_idx_q <= LAST_IDX;
    end else begin
      sresetn_q <= 1'b1;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      if (abort_hit) begin
        // No latch pulse on abort: pads keep their previous config.
        state_q   <= S_IDLE;
        busy_q    <= 1'b0;
        aborted_q <= 1'b1;
        sclk_q    <= 1'b0;
        sload_q   <= 1'b0;
        cfg_idx_q <= LAST_IDX;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (host.start) begin
              state_q   <= S_FETCH;
              busy_q    <= 1'b1;
              cfg_idx_q <= LAST_IDX;
            end
          end
          S_FETCH: begin
            state_q <= S_SETUP;
            sclk_q  <= 1'b0;
            sdata_q <= next_msb;
          end
          S_SETUP: begin
            if (hc_done) begin
              state_q <= S_HIGH;
              sclk_q  <= 1'b1;
            end
          end
          S_HIGH: begin
            if (hc_done) begin
              sclk_q <= 1'b0;
              if (!last_bit) begin
                state_q <= S_SETUP;
                sdata_q <= next_msb;
              end else if (cfg_idx_q != '0) begin
                state_q   <= S_FETCH;
                cfg_idx_q <= cfg_idx_q - IDX_W'(1);
              end else begin
                state_q <= S_LOAD;
                sload_q <= 1'b1;
              end
            end
          end
          S_LOAD: begin
            if (hc_done) begin
              state_q <= S_FIN;
              sload_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
          S_FIN: begin
            state_q   <= S_IDLE;
            cfg_idx_q <= LAST_IDX;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign host.busy     = busy_q;
  assign host.done     = done_q;
  assign host.aborted  = aborted_q;
  assign host.cfg_idx  = cfg_idx_q;
  assign serial_clock  = sclk_q;
  assign serial_data   = sdata_q;
  assign serial_load   = sload_q;
  assign serial_resetn = sresetn_q;
  assign dbg_state_o   = state_q;
endmodule
